// File: rtl/hsi_s_rx_frame_ctrl_if.sv
// Decoder-to-frame-controller bus. It carries the decoded byte stream in and
// the frame results out.
// The slave modport is the receive frame controller. The master modport is
// the side that feeds decoded bytes and consumes the frame results.
interface hsi_s_rx_frame_ctrl_if;
    logic [7:0] dec_d;
    logic       dec_d_rdy;
    logic       dec_err;
    logic [7:0] rx_flag;
    logic       rx_frame_end;
    logic       rx_err;
    logic [7:0] rx_d;
    logic       rx_d_rdy;
    logic       rx_busy;
    logic [7:0] rx_err_cnt;

    modport master (
        output dec_d, dec_d_rdy, dec_err,
        input  rx_flag, rx_frame_end, rx_err, rx_d, rx_d_rdy, rx_busy, rx_err_cnt
    );

    modport slave (
        input  dec_d, dec_d_rdy, dec_err,
        output rx_flag, rx_frame_end, rx_err, rx_d, rx_d_rdy, rx_busy, rx_err_cnt
    );
endinterface

// File: rtl/hsi_s_rx_frame_ctrl.sv
// Slave-side receive frame controller.
// It parses each frame as a flag byte, a flag-dependent payload and then a
// CRC16 high byte and low byte.
// The CRC is CRC16-CCITT over every byte of the frame, including the CRC
// bytes themselves, so a good frame leaves a residue of zero.
// The controller forwards payload bytes. It ends each frame with either an
// rx_frame_end pulse or an rx_err pulse.
// Optional feature macro: HSI_RX_ERR_CNT_EN enables a saturating error
// counter on rx_err_cnt. Without the macro, rx_err_cnt reads 0.
//
// state   | meaning
// IDLE    | waiting for a flag byte
// PAYLOAD | receiving flag-dependent payload bytes
// CRC_HI  | waiting for CRC high byte
// CRC_LO  | waiting for CRC low byte
// CHECK   | one cycle: residue check, pulse frame_end or err
`ifndef FLAG_CONTROL_COMMAND_WORD
`define FLAG_CONTROL_COMMAND_WORD 8'hA1
`endif
`ifndef FLAG_STATUS_REQUEST
`define FLAG_STATUS_REQUEST 8'hA2
`endif
`ifndef FLAG_DATA_PACKET_REQUEST
`define FLAG_DATA_PACKET_REQUEST 8'hA3
`endif

module hsi_s_rx_frame_ctrl #(
    parameter int CMD_LEN  = 2,
    parameter int STAT_LEN = 0,
    parameter int DREQ_LEN = 1,
    parameter int TIMEOUT  = 200
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clk_en,
    hsi_s_rx_frame_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PAYLOAD, CRC_HI, CRC_LO, CHECK} state_t;

    state_t      state, state_nxt;
    logic [15:0] crc;
    logic [7:0]  byte_cnt;
    logic [7:0]  tick_cnt;
    logic [7:0]  rx_flag_q;
    logic [7:0]  rx_d_q;
    logic        rx_d_rdy_q;
    logic        err_q;
    logic        rx_err_int;
    logic        rx_end_int;

    logic        in_frame, byte_ok, timeout_hit, abort, flag_take, data_take;
    logic        flag_known;
    logic [7:0]  flag_len;

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    // Flag decode and the byte/abort qualifiers shared by FSM and datapath.
    always_comb begin
        flag_known = 1'b1;
        flag_len   = 8'd0;
        case (bus.dec_d)
            `FLAG_CONTROL_COMMAND_WORD: flag_len = 8'(CMD_LEN);
            `FLAG_STATUS_REQUEST:       flag_len = 8'(STAT_LEN);
            `FLAG_DATA_PACKET_REQUEST:  flag_len = 8'(DREQ_LEN);
            default:                    flag_known = 1'b0;
        endcase
        in_frame    = (state == PAYLOAD) || (state == CRC_HI) || (state == CRC_LO);
        // Error wins over a coincident byte: the byte is discarded.
        byte_ok     = bus.dec_d_rdy && !bus.dec_err;
        timeout_hit = in_frame && clk_en && !bus.dec_d_rdy && (tick_cnt == 8'(TIMEOUT - 1));
        abort       = in_frame && (bus.dec_err || timeout_hit);
        flag_take   = (state == IDLE) && byte_ok;
        data_take   = in_frame && byte_ok;
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flag_take && flag_known)
                         state_nxt = (flag_len == 8'd0) ? CRC_HI : PAYLOAD;
            PAYLOAD: if (abort) state_nxt = IDLE;
                     else if (data_take && byte_cnt == 8'd1) state_nxt = CRC_HI;
            CRC_HI:  if (abort) state_nxt = IDLE;
                     else if (data_take) state_nxt = CRC_LO;
            CRC_LO:  if (abort) state_nxt = IDLE;
                     else if (data_take) state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: residue check in CHECK, registered errors otherwise.
    always_comb begin
        rx_end_int = (state == CHECK) && (crc == 16'h0000);
        rx_err_int = err_q || ((state == CHECK) && (crc != 16'h0000));
    end

    // Datapath: flag, CRC, payload forwarding, byte and timeout counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_flag_q  <= 8'h00;
            crc        <= 16'hFFFF;
            byte_cnt   <= 8'd0;
            rx_d_q     <= 8'h00;
            rx_d_rdy_q <= 1'b0;
            err_q      <= 1'b0;
            tick_cnt   <= 8'd0;
        end else begin
            rx_d_rdy_q <= 1'b0;
            err_q      <= abort || (flag_take && !flag_known);
            if (flag_take) begin
                rx_flag_q <= bus.dec_d;
                crc       <= flag_known ? crc_upd(16'hFFFF, bus.dec_d) : 16'hFFFF;
                byte_cnt  <= flag_len;
            end
            if (data_take) begin
                crc <= crc_upd(crc, bus.dec_d);
                if (state == PAYLOAD) begin
                    rx_d_q     <= bus.dec_d;
                    rx_d_rdy_q <= 1'b1;
                    byte_cnt   <= byte_cnt - 8'd1;
                end
            end
            if (abort || state == CHECK) crc <= 16'hFFFF;
            if (!in_frame || abort || data_take) tick_cnt <= 8'd0;
            else if (clk_en)                     tick_cnt <= tick_cnt + 8'd1;
        end
    end

    assign bus.rx_flag      = rx_flag_q;
    assign bus.rx_d         = rx_d_q;
    assign bus.rx_d_rdy     = rx_d_rdy_q;
    assign bus.rx_frame_end = rx_end_int;
    assign bus.rx_err       = rx_err_int;
    assign bus.rx_busy      = (state != IDLE);

`ifdef HSI_RX_ERR_CNT_EN
    logic [7:0] err_cnt;

    // Saturating count of rx_err pulses, cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                              err_cnt <= 8'd0;
        else if (rx_err_int && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end

    assign bus.rx_err_cnt = err_cnt;
`else
    assign bus.rx_err_cnt = 8'h00;
`endif
endmodule

// File: doc/hsi_s_rx_frame_ctrl.md
Name: hsi_s_rx_frame_ctrl

Overview:
Slave-side receive frame controller. It sits between the line decoder and hsi_s_tx_ctrl, taking decoded bytes and parsing each frame as flag byte, flag-dependent payload, then CRC16. It checks the CRC, then raises rx_frame_end or rx_err with rx_flag valid, which is the trigger hsi_s_tx_ctrl uses to start a response. Payload bytes are forwarded to the sub-device side.

Parameters:
CMD_LEN, 2, payload bytes following `FLAG_CONTROL_COMMAND_WORD
STAT_LEN, 0, payload bytes following `FLAG_STATUS_REQUEST
DREQ_LEN, 1, payload bytes following `FLAG_DATA_PACKET_REQUEST
TIMEOUT, 200, max clk_en ticks between bytes inside a frame (1..255)

Ports:
clk  in  1  system clock, single clock domain
n_rst  in  1  asynchronous active-low reset
clk_en  in  1  bit-rate tick, shared with coder
dec_d  in  8  decoded byte
dec_d_rdy  in  1  one-cycle strobe, dec_d valid
dec_err  in  1  one-cycle decoder code/sync error strobe
rx_flag  out  8  flag of current/last frame
rx_frame_end  out  1  one-cycle pulse, good frame
rx_err  out  1  one-cycle pulse, frame aborted/bad
rx_d  out  8  payload byte
rx_d_rdy  out  1  one-cycle payload strobe
rx_busy  out  1  high while a frame is in progress
rx_err_cnt  out  8  error counter (see Optional Feature)

Behaviour:
- Reset, asynchronous: all outputs 0, state IDLE, crc 16'hFFFF, timeout counter 0.
- CRC is CRC16-CCITT: poly 0x1021, init 0xFFFF, MSB-first, no reflection, no final XOR.
  - Updated bytewise in one cycle on every accepted byte: flag, payload and both CRC bytes.
  - Transmitter appends its CRC high byte first, so a good frame leaves residue 16'h0000.
- States:
  - IDLE: on dec_d_rdy, load rx_flag <= dec_d, crc <= update(FFFF, dec_d), set rx_busy.
    - Flag equals one of the three `FLAG_* codes: go to PAYLOAD, or to CRC_HI if its length is 0. Load byte counter with the length.
    - Unknown flag: pulse rx_err, stay IDLE, rx_busy back to 0.
  - PAYLOAD: each dec_d_rdy registers rx_d <= dec_d, pulses rx_d_rdy one cycle later, updates crc and decrements the counter. The last byte moves to CRC_HI.
  - CRC_HI: the byte updates crc, then go to CRC_LO.
  - CRC_LO: the byte updates crc, then go to CHECK.
  - CHECK, one cycle: if crc==0, pulse rx_frame_end, else pulse rx_err. Then go to IDLE, rx_busy=0, crc<=FFFF.
- Latency: rx_frame_end/rx_err is high in the cycle after the clock edge that samples the final CRC byte strobe.
- rx_flag is stable during and after the pulse, held until the next flag byte is accepted. hsi_s_tx_ctrl ANDs it with rx_frame_end.
- Timeout: outside IDLE, the counter increments on clk_en and clears on every dec_d_rdy. When it reaches TIMEOUT: pulse rx_err, go to IDLE.
- dec_err in any state other than IDLE/CHECK: pulse rx_err, go to IDLE. dec_err in IDLE is ignored.
- dec_err and dec_d_rdy in the same cycle: error wins, byte discarded.
- dec_d_rdy during CHECK: byte ignored (decoder byte spacing ≥9 clk_en makes this a protocol violation).
- rx_frame_end and rx_err are never high together. A data frame is never signalled good if any error occurred within it.

Optional Feature:
Macro HSI_RX_ERR_CNT_EN.
- Defined: rx_err_cnt is an 8-bit counter, incremented on every rx_err pulse, saturating at 255, cleared only by n_rst.
- Undefined: rx_err_cnt tied to 8'h00; no counter logic.

Test Plan:
- Status-request frame (flag + 2 correct CRC bytes, 10 clk_en byte spacing) -> rx_frame_end pulse 1 cycle after last strobe, rx_flag=`FLAG_STATUS_REQUEST, rx_d_rdy never asserted, rx_err=0.
- Command frame with payload 8'hA5, 8'h3C plus correct CRC -> rx_d_rdy pulses with A5 then 3C, then rx_frame_end. Repeat with CRC low byte XOR 8'h01 -> rx_err pulse instead, rx_frame_end=0.
- Data-request frame, then stall 200 clk_en ticks after the payload byte -> rx_err on the 200th tick, rx_busy=0. A following good frame is accepted normally.
- Flag byte 8'hFF (not a defined flag) -> rx_err in the next cycle, state IDLE, next valid frame OK.
- dec_err coincident with the 2nd command payload byte -> rx_err, that byte not forwarded. Assert n_rst mid-frame -> all outputs 0 immediately, then a new frame is accepted.
- With HSI_RX_ERR_CNT_EN: 3 bad frames -> rx_err_cnt=3; 300 bad frames -> rx_err_cnt=255. Without the macro -> rx_err_cnt stays 0.
